// File: rtl/spi_fl_pkg.sv
// Shared constants and types for the SPI flash controller and the SPI master:
// flash opcodes, master transfer types, CPU request encodings and FSM states.
package spi_fl_pkg;

    // Flash opcodes
    localparam logic [7:0] CMD_READ = 8'h03;
    localparam logic [7:0] CMD_WREN = 8'h06;
    localparam logic [7:0] CMD_PP   = 8'h02;
    localparam logic [7:0] CMD_SE   = 8'h20;
    localparam logic [7:0] CMD_RDSR = 8'h05;

    // SPI master transfer types (spi_commtype)
    localparam logic [2:0] CT_CMD    = 3'b000;  // opcode only
    localparam logic [2:0] CT_STATUS = 3'b001;  // opcode, one status byte back
    localparam logic [2:0] CT_READ   = 3'b010;  // opcode + address, data word back
    localparam logic [2:0] CT_WRSR   = 3'b011;  // opcode + status byte out
    localparam logic [2:0] CT_PROG   = 3'b100;  // opcode + address + data word out
    localparam logic [2:0] CT_ERASE  = 3'b101;  // opcode + address

    // CPU request operations (req_op)
    localparam logic [1:0] RQ_READ   = 2'b00;
    localparam logic [1:0] RQ_PROG   = 2'b01;
    localparam logic [1:0] RQ_ERASE  = 2'b10;
    localparam logic [1:0] RQ_STATUS = 2'b11;

    // Single-command engine states
    typedef enum logic [1:0] {
        STEP_IDLE, STEP_ISSUE, STEP_WAIT_BUSY, STEP_WAIT_DONE
    } step_state_t;

    // Op sequencer states
    typedef enum logic [1:0] {
        SEQ_IDLE, SEQ_RUN, SEQ_NEXT, SEQ_RESP
    } seq_state_t;

    // Which command of a sequence is current
    typedef enum logic [1:0] {
        PH_WREN, PH_MAIN, PH_POLL
    } phase_t;

    // Combined controller view exposed for debug
    typedef enum logic [2:0] {
        ST_IDLE, ST_ISSUE, ST_WAIT_BUSY, ST_WAIT_DONE, ST_NEXT, ST_RESP
    } fl_state_t;

    // Transfer types that return an answer word from the master
    function automatic logic ct_has_answer(input logic [2:0] ct);
        return (ct == CT_STATUS) || (ct == CT_READ);
    endfunction

endpackage

// File: rtl/spi_fl_step.sv
// Runs one SPI master command: waits for the master to be ready, presents the
// command for a single spi_validflag cycle, follows tready low then high, and
// captures the answer word for answer-bearing transfers.
module spi_fl_step
    import spi_fl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  cmd,
    input  logic [2:0]  ctype,
    input  logic [23:0] addr,
    input  logic [31:0] wdata,
    output logic        done,
    output logic [31:0] answer,
    output step_state_t state,
    output logic [31:0] spi_data_in,
    output logic [23:0] spi_address,
    output logic [7:0]  spi_command,
    output logic [2:0]  spi_commtype,
    output logic        spi_validflag,
    input  logic        spi_tready,
    input  logic        spi_validflag_out,
    input  logic [31:0] spi_data_out
);

    logic pend;      // start seen while master not ready
    logic ans_flag;  // answer captured since the last ISSUE

    // Command engine; the master's answer pulse is captured in any state so a
    // pulse coinciding with tready rising is never lost.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= STEP_IDLE;
            pend          <= 1'b0;
            ans_flag      <= 1'b0;
            answer        <= 32'h0;
            done          <= 1'b0;
            spi_data_in   <= 32'h0;
            spi_address   <= 24'h0;
            spi_command   <= 8'h0;
            spi_commtype  <= 3'b0;
            spi_validflag <= 1'b0;
        end else begin
            done          <= 1'b0;
            spi_validflag <= 1'b0;
            if (spi_validflag_out) begin
                answer   <= spi_data_out;
                ans_flag <= 1'b1;
            end
            case (state)
                STEP_IDLE: begin
                    if (start || pend) begin
                        if (spi_tready) begin
                            state         <= STEP_ISSUE;
                            pend          <= 1'b0;
                            ans_flag      <= 1'b0;
                            spi_validflag <= 1'b1;
                            spi_command   <= cmd;
                            spi_commtype  <= ctype;
                            spi_address   <= addr;
                            spi_data_in   <= wdata;
                        end else begin
                            pend <= 1'b1;
                        end
                    end
                end
                STEP_ISSUE: state <= STEP_WAIT_BUSY;
                // tready lags the request by some sclk periods; wait for it to drop
                STEP_WAIT_BUSY: if (!spi_tready) state <= STEP_WAIT_DONE;
                STEP_WAIT_DONE: begin
                    if (spi_tready && (!ct_has_answer(spi_commtype) ||
                                       ans_flag || spi_validflag_out)) begin
                        done  <= 1'b1;
                        state <= STEP_IDLE;
                    end
                end
                default: state <= STEP_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/spi_flash_ctrl.sv
// SPI flash controller: turns CPU read/program/erase/status requests into
// sequences of SPI master commands, polling WIP after program and erase.
// Handshake: a request is taken when req_valid && req_ready at a rising edge;
// req_ready is high only while idle, and each request yields exactly one
// rsp_valid pulse.
module spi_flash_ctrl
    import spi_fl_pkg::*;
#(
    parameter logic [15:0] POLL_MAX = 16'd65535,
    parameter int          WIP_BIT  = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [23:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] spi_data_in,
    output logic [23:0] spi_address,
    output logic [7:0]  spi_command,
    output logic [2:0]  spi_commtype,
    output logic        spi_validflag,
    input  logic        spi_tready,
    input  logic        spi_validflag_out,
    input  logic [31:0] spi_data_out,
    output fl_state_t   dbg_state
);

    seq_state_t  seq;
    phase_t      phase;
    step_state_t step_state;
    logic [1:0]  op_q;
    logic [23:0] addr_q;
    logic [31:0] wdata_q;
    logic [15:0] poll_cnt;
    logic        step_start;
    logic        step_done;
    logic [31:0] answer;
    logic [7:0]  step_cmd;
    logic [2:0]  step_ct;

    // Opcode and transfer type of the current step of the sequence
    always_comb begin
        step_cmd = CMD_RDSR;
        step_ct  = CT_STATUS;
        case (phase)
            PH_WREN: begin
                step_cmd = CMD_WREN;
                step_ct  = CT_CMD;
            end
            PH_MAIN: begin
                case (op_q)
                    RQ_READ:  begin step_cmd = CMD_READ; step_ct = CT_READ;  end
                    RQ_PROG:  begin step_cmd = CMD_PP;   step_ct = CT_PROG;  end
                    RQ_ERASE: begin step_cmd = CMD_SE;   step_ct = CT_ERASE; end
                    default:  begin step_cmd = CMD_RDSR; step_ct = CT_STATUS; end
                endcase
            end
            default: ;
        endcase
    end

    // Op sequencer: accept, launch steps, decide after each step, respond
    always_ff @(posedge clk) begin
        if (!rst) begin
            seq        <= SEQ_IDLE;
            phase      <= PH_MAIN;
            op_q       <= RQ_READ;
            addr_q     <= 24'h0;
            wdata_q    <= 32'h0;
            poll_cnt   <= 16'h0;
            step_start <= 1'b0;
            req_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_err    <= 1'b0;
            rsp_rdata  <= 32'h0;
        end else begin
            step_start <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_err    <= 1'b0;
            case (seq)
                SEQ_IDLE: begin
                    if (req_valid && req_ready) begin
                        op_q       <= req_op;
                        addr_q     <= req_addr;
                        wdata_q    <= req_wdata;
                        poll_cnt   <= 16'h0;
                        phase      <= (req_op == RQ_PROG || req_op == RQ_ERASE) ? PH_WREN : PH_MAIN;
                        step_start <= 1'b1;
                        req_ready  <= 1'b0;
                        seq        <= SEQ_RUN;
                    end
                end
                SEQ_RUN: if (step_done) seq <= SEQ_NEXT;
                SEQ_NEXT: begin
                    case (phase)
                        PH_WREN: begin
                            phase      <= PH_MAIN;
                            step_start <= 1'b1;
                            seq        <= SEQ_RUN;
                        end
                        PH_MAIN: begin
                            if (op_q == RQ_READ || op_q == RQ_STATUS) begin
                                rsp_rdata <= (op_q == RQ_READ) ? answer : {24'h0, answer[7:0]};
                                rsp_valid <= 1'b1;
                                seq       <= SEQ_RESP;
                            end else begin
                                phase      <= PH_POLL;
                                poll_cnt   <= poll_cnt + 16'd1;
                                step_start <= 1'b1;
                                seq        <= SEQ_RUN;
                            end
                        end
                        default: begin
                            if (!answer[WIP_BIT]) begin
                                rsp_valid <= 1'b1;
                                seq       <= SEQ_RESP;
                            end else if (poll_cnt >= POLL_MAX) begin
                                rsp_valid <= 1'b1;
                                rsp_err   <= 1'b1;
                                seq       <= SEQ_RESP;
                            end else begin
                                poll_cnt   <= poll_cnt + 16'd1;
                                step_start <= 1'b1;
                                seq        <= SEQ_RUN;
                            end
                        end
                    endcase
                end
                SEQ_RESP: begin
                    req_ready <= 1'b1;
                    seq       <= SEQ_IDLE;
                end
                default: seq <= SEQ_IDLE;
            endcase
        end
    end

    // Combined state view; a launched step not yet issued reads as ISSUE
    always_comb begin
        dbg_state = ST_IDLE;
        case (seq)
            SEQ_RUN: begin
                case (step_state)
                    STEP_WAIT_BUSY: dbg_state = ST_WAIT_BUSY;
                    STEP_WAIT_DONE: dbg_state = ST_WAIT_DONE;
                    default:        dbg_state = ST_ISSUE;
                endcase
            end
            SEQ_NEXT: dbg_state = ST_NEXT;
            SEQ_RESP: dbg_state = ST_RESP;
            default:  dbg_state = ST_IDLE;
        endcase
    end

    spi_fl_step u_step (
        .clk               (clk),
        .rst               (rst),
        .start             (step_start),
        .cmd               (step_cmd),
        .ctype             (step_ct),
        .addr              (addr_q),
        .wdata             (wdata_q),
        .done              (step_done),
        .answer            (answer),
        .state             (step_state),
        .spi_data_in       (spi_data_in),
        .spi_address       (spi_address),
        .spi_command       (spi_command),
        .spi_commtype      (spi_commtype),
        .spi_validflag     (spi_validflag),
        .spi_tready        (spi_tready),
        .spi_validflag_out (spi_validflag_out),
        .spi_data_out      (spi_data_out)
    );

endmodule

// File: tb/tb_spi_flash_ctrl.sv
// Bench for spi_flash_ctrl: SPI master stub, request-level reference model,
// directed scenarios and randomized requests.
module tb_spi_flash_ctrl;
    import spi_fl_pkg::*;

    localparam logic [15:0] POLL = 16'd4;
    localparam int          WIP  = 0;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = 2'b0;
    logic [23:0] req_addr = 24'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] spi_data_in;
    logic [23:0] spi_address;
    logic [7:0]  spi_command;
    logic [2:0]  spi_commtype;
    logic        spi_validflag;
    logic        spi_tready = 1'b1;
    logic        spi_validflag_out = 1'b0;
    logic [31:0] spi_data_out = 32'h0;
    fl_state_t   dbg_state;

    spi_flash_ctrl #(.POLL_MAX(POLL), .WIP_BIT(WIP)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .spi_data_in(spi_data_in), .spi_address(spi_address),
        .spi_command(spi_command), .spi_commtype(spi_commtype),
        .spi_validflag(spi_validflag), .spi_tready(spi_tready),
        .spi_validflag_out(spi_validflag_out), .spi_data_out(spi_data_out),
        .dbg_state(dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [66:0] exp_q[$];
    logic [66:0] act_q[$];
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic [31:0] last_rdata = 32'h0;
    int          acc_cyc;
    int          first_vf_cyc = -1;

    // stub configuration
    logic [31:0] stub_read_data = 32'h0;
    logic [31:0] stat_list[$];
    logic [31:0] stat_stuck = 32'h0;
    int          stat_idx = 0;
    bit          same_cycle = 1'b0;

    task automatic check(input string tag, input logic [66:0] got, input logic [66:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // A command as seen on the bus; address/data only where the command uses them
    function automatic logic [66:0] pack_txn(input logic [7:0] c, input logic [2:0] t,
                                             input logic [23:0] a, input logic [31:0] d);
        logic [23:0] am;
        logic [31:0] dm;
        am = (c == CMD_READ || c == CMD_PP || c == CMD_SE) ? a : 24'h0;
        dm = (c == CMD_PP) ? d : 32'h0;
        return {c, t, am, dm};
    endfunction

    function automatic logic [31:0] stat_at(input int i);
        return (i < stat_list.size()) ? stat_list[i] : stat_stuck;
    endfunction

    // ---------------- reference model ----------------
    task automatic model_req(input logic [1:0] op, input logic [23:0] a, input logic [31:0] d);
        logic [31:0] w;
        int n;
        exp_q.delete();
        exp_err = 1'b0;
        if (op == RQ_READ) begin
            exp_q.push_back(pack_txn(8'h03, 3'b010, a, d));
            exp_rdata = stub_read_data;
        end else if (op == RQ_STATUS) begin
            exp_q.push_back(pack_txn(8'h05, 3'b001, a, d));
            w = stat_at(0);
            exp_rdata = {24'h0, w[7:0]};
        end else begin
            exp_q.push_back(pack_txn(8'h06, 3'b000, a, d));
            if (op == RQ_PROG) exp_q.push_back(pack_txn(8'h02, 3'b100, a, d));
            else               exp_q.push_back(pack_txn(8'h20, 3'b101, a, d));
            exp_rdata = last_rdata;
            n = 0;
            while (n < int'(POLL)) begin
                exp_q.push_back(pack_txn(8'h05, 3'b001, a, d));
                w = stat_at(n);
                n++;
                if (!w[WIP]) break;
                if (n == int'(POLL)) exp_err = 1'b1;
            end
        end
    endtask

    // ---------------- SPI master stub ----------------
    int          stb_phase = 0;
    int          stb_lag, stb_busy;
    bit          stb_ans;
    logic [31:0] stb_word;

    always @(negedge clk) begin
        if (!rst) begin
            stb_phase         = 0;
            spi_tready        = 1'b1;
            spi_validflag_out = 1'b0;
            spi_data_out      = $urandom;
        end else begin
            spi_validflag_out = 1'b0;
            spi_data_out      = $urandom;
            case (stb_phase)
                0: if (spi_validflag) begin
                    act_q.push_back(pack_txn(spi_command, spi_commtype, spi_address, spi_data_in));
                    if (first_vf_cyc < 0) first_vf_cyc = cyc;
                    stb_ans  = (spi_commtype == CT_STATUS) || (spi_commtype == CT_READ);
                    stb_word = $urandom;
                    if (spi_command == CMD_READ) stb_word = stub_read_data;
                    else if (spi_command == CMD_RDSR) begin
                        stb_word = stat_at(stat_idx);
                        stat_idx++;
                    end
                    stb_lag  = $urandom_range(0, 2);
                    stb_busy = $urandom_range(2, 5);
                    if (stb_lag == 0) begin
                        spi_tready = 1'b0;
                        stb_phase  = 2;
                    end else stb_phase = 1;
                end
                1: begin
                    stb_lag--;
                    if (stb_lag == 0) begin
                        spi_tready = 1'b0;
                        stb_phase  = 2;
                    end
                end
                default: begin
                    stb_busy--;
                    if (stb_ans && !same_cycle && stb_busy == 1) begin
                        spi_validflag_out = 1'b1;
                        spi_data_out      = stb_word;
                    end
                    if (stb_busy == 0) begin
                        spi_tready = 1'b1;
                        stb_phase  = 0;
                        if (stb_ans && same_cycle) begin
                            spi_validflag_out = 1'b1;
                            spi_data_out      = stb_word;
                        end
                    end
                end
            endcase
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive_req(input string tag, input logic [1:0] op,
                             input logic [23:0] a, input logic [31:0] d);
        int n = 0;
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("%s_ready", tag), 67'(req_ready), 67'(1));
        act_q.delete();
        stat_idx     = 0;
        first_vf_cyc = -1;
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = a;
        req_wdata = d;
        @(negedge clk);
        acc_cyc   = cyc;
        req_valid = 1'b0;
        req_op    = 2'($urandom_range(0, 3));
        req_addr  = 24'($urandom);
        req_wdata = $urandom;
    endtask

    task automatic run_req(input string tag, input logic [1:0] op, input logic [23:0] a,
                           input logic [31:0] d, input bit inject);
        bit got = 1'b0;
        int n = 0;
        int lat, extra;
        model_req(op, a, d);
        drive_req(tag, op, a, d);
        while (!got && n < 3000) begin
            if (rsp_valid) got = 1'b1;
            else begin
                if (inject && n == 6 && !req_ready) begin
                    req_valid = 1'b1;
                    req_op    = RQ_READ;
                end else req_valid = 1'b0;
                @(negedge clk);
                n++;
            end
        end
        req_valid = 1'b0;
        check($sformatf("%s_rsp_seen", tag), 67'(got), 67'(1));
        if (got) begin
            check($sformatf("%s_rdata", tag), 67'(rsp_rdata), 67'(exp_rdata));
            check($sformatf("%s_err", tag), 67'(rsp_err), 67'(exp_err));
            lat = first_vf_cyc - acc_cyc;
            check($sformatf("%s_latency_ok", tag), 67'(lat >= 1 && lat <= 2), 67'(1));
            check($sformatf("%s_nsteps", tag), 67'(act_q.size()), 67'(exp_q.size()));
            for (int i = 0; i < exp_q.size(); i++)
                check($sformatf("%s_step%0d", tag, i),
                      (i < act_q.size()) ? act_q[i] : 67'h0, exp_q[i]);
            @(negedge clk);
            check($sformatf("%s_rsp_one_cycle", tag), 67'(rsp_valid), 67'(0));
            check($sformatf("%s_ready_after", tag), 67'(req_ready), 67'(1));
            if (inject) begin
                extra = 0;
                repeat (20) begin
                    @(negedge clk);
                    if (rsp_valid) extra++;
                end
                check($sformatf("%s_extra_rsp", tag), 67'(extra), 67'(0));
                check($sformatf("%s_extra_steps", tag), 67'(act_q.size()), 67'(exp_q.size()));
            end
        end
        last_rdata = exp_rdata;
    endtask

    task automatic check_reset_outputs(input string tag);
        check($sformatf("%s_req_ready", tag), 67'(req_ready), 67'(1));
        check($sformatf("%s_rsp_valid", tag), 67'(rsp_valid), 67'(0));
        check($sformatf("%s_rsp_err", tag), 67'(rsp_err), 67'(0));
        check($sformatf("%s_rsp_rdata", tag), 67'(rsp_rdata), 67'(0));
        check($sformatf("%s_validflag", tag), 67'(spi_validflag), 67'(0));
        check($sformatf("%s_spi_fields", tag),
              67'({spi_command, spi_commtype, spi_address, spi_data_in}), 67'(0));
        check($sformatf("%s_state", tag), 67'(dbg_state), 67'(ST_IDLE));
    endtask

    // ---------------- test sequence ----------------
    initial begin
        bit reached;
        int n, sz, k;
        logic [31:0] w;

        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b1;
        @(negedge clk);

        // read word
        stub_read_data = 32'hDEADBEEF;
        same_cycle = 1'b0;
        run_req("read", RQ_READ, 24'h000100, 32'h0, 1'b0);

        // program with two busy polls then ready
        stat_list = '{32'h01, 32'h01, 32'h00};
        run_req("prog", RQ_PROG, 24'h000200, 32'h12345678, 1'b0);

        // erase with status stuck busy -> timeout after POLL polls
        stat_list.delete();
        stat_stuck = 32'h03;
        run_req("erase_to", RQ_ERASE, 24'h00A000, 32'h0, 1'b0);

        // status with answer pulse in the same cycle tready rises
        same_cycle = 1'b1;
        stat_list = '{32'h00000042};
        run_req("status_same", RQ_STATUS, 24'h0, 32'h0, 1'b0);
        same_cycle = 1'b0;

        // request pulsed while a program is busy must be ignored
        stat_list = '{32'h01, 32'h00};
        run_req("prog_inject", RQ_PROG, 24'h123456, 32'hA5A5F00F, 1'b1);

        // reset during WAIT_DONE of the page-program step
        stat_list.delete();
        stat_stuck = 32'h01;
        drive_req("rst_mid", RQ_PROG, 24'h000300, 32'hCAFEF00D);
        reached = 1'b0;
        n = 0;
        while (!reached && n < 500) begin
            if (act_q.size() >= 2 && dbg_state == ST_WAIT_DONE) reached = 1'b1;
            else begin
                @(negedge clk);
                n++;
            end
        end
        check("rst_mid_reached_pp_wait", 67'(reached), 67'(1));
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("rst_mid");
        @(negedge clk);
        rst = 1'b1;
        sz = act_q.size();
        repeat (20) @(negedge clk);
        check("rst_mid_no_more_cmds", 67'(act_q.size()), 67'(sz));
        last_rdata = 32'h0;
        stub_read_data = 32'h0BADF00D;
        run_req("read_after_rst", RQ_READ, 24'h000400, 32'h0, 1'b0);

        // randomized requests
        for (int i = 0; i < 24; i++) begin
            stub_read_data = $urandom;
            same_cycle = 1'($urandom_range(0, 1));
            stat_list.delete();
            k = $urandom_range(0, 5);
            for (int j = 0; j < k; j++) begin
                w = $urandom;
                w[WIP] = 1'b1;
                stat_list.push_back(w);
            end
            w = $urandom;
            w[WIP] = 1'b0;
            if ($urandom_range(0, 3) != 0) stat_list.push_back(w);
            stat_stuck = $urandom;
            run_req($sformatf("rnd%0d", i), 2'($urandom_range(0, 3)), 24'($urandom), $urandom, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
